// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Keeps one imem request in flight and drops responses that belong to redirected paths.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushIFID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D,
    output logic [31:0] pc_F
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HELD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;

    logic        redir_s;
    logic        deliver_s;
    logic [31:0] deliver_data_s;
    logic [31:0] pc_inc_s;
    logic [31:0] pc_seq_s;

    assign redir_s    = redirect_valid & ~stallD;
    assign pc_inc_s   = pc_q + 32'd4;
    assign imem_req   = (state_q == S_REQ) & ~stallF;
    assign imem_addr  = pc_q;
    assign pc_F       = pc_q;
    assign instr_D    = instr_q;
    assign pc_plus4_D = pcp4_q;
    assign valid_D    = valid_q;

    // Fetch FSM: request/response sequencing, stale-response kill and hold buffer.
    always_comb begin
        state_d        = state_q;
        pc_seq_s       = pc_q;
        kill_d         = kill_q;
        hold_d         = hold_q;
        deliver_s      = 1'b0;
        deliver_data_s = hold_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req && imem_gnt) begin
                    state_d = S_WAIT;
                    kill_d  = redir_s;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (kill_q || redir_s) begin
                        deliver_s = 1'b0;
                    end else if (!stallD) begin
                        deliver_s      = 1'b1;
                        deliver_data_s = imem_rdata;
                        pc_seq_s       = pc_inc_s;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HELD;
                    end
                end else if (redir_s) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            S_HELD: begin
                if (redir_s) begin
                    state_d = S_REQ;
                end else if (!stallD) begin
                    deliver_s = 1'b1;
                    pc_seq_s  = pc_inc_s;
                    state_d   = S_REQ;
                end else begin
                    state_d = S_HELD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A redirect wins over any sequential +4 advance.
        pc_d = redir_s ? {redirect_pc[31:2], 2'b00} : pc_seq_s;
    end

    // IF/ID register priority: stall, flush, delivery, bubble.
    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (stallD) begin
            valid_d = valid_q;
        end else if (flushIFID) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (deliver_s) begin
            instr_d = deliver_data_s;
            pcp4_d  = pc_inc_s;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            hold_q  <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Drives the decode stage with instr_D, pc_plus4_D and valid_D.
- Consumes stallF, stallD and flushIFID from the hazard unit, plus the redirect target (taken branch, j/jal, jr/jalr) resolved in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0000, instruction word driven into ID for bubbles/flushes

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stallF  input  1  hazard unit: do not issue a new fetch request
stallD  input  1  hazard unit: hold IF/ID contents
flushIFID  input  1  hazard unit: load bubble into IF/ID
redirect_valid  input  1  ID resolved a taken branch/jump; redirect_pc is valid
redirect_pc  input  32  new fetch address
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (word aligned)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
instr_D  output  32  instruction in IF/ID
pc_plus4_D  output  32  PC+4 of instr_D
valid_D  output  1  instr_D is a real instruction
pc_F  output  32  current fetch PC (debug/trace)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc_F=RESET_PC, kill=0, hold buffer empty.
  - instr_D=NOP_INSTR, pc_plus4_D=0, valid_D=0, imem_req=0.
- Combinational outputs:
  - imem_req = (state==REQ) & !stallF.
  - imem_addr = pc_F.
- IDLE:
  - Unconditionally go to REQ next cycle, so the first request appears the cycle after rst_n rises.
- REQ:
  - If imem_req & imem_gnt, go to WAIT.
  - Otherwise stay; pc_F stays stable while waiting.
- WAIT:
  - imem_gnt is ignored.
  - On imem_rvalid with kill=1: discard data, clear kill, go to REQ.
  - On imem_rvalid with kill=0 and !stallD: load instr_D=imem_rdata, pc_plus4_D=pc_F+4, valid_D=1; set pc_F=pc_F+4; go to REQ.
  - On imem_rvalid with kill=0 and stallD: capture data into the hold buffer, go to HELD.
- HELD:
  - When stallD=0, transfer the buffer into IF/ID (valid_D=1, pc_plus4_D=pc_F+4), set pc_F=pc_F+4, go to REQ.
- One outstanding request maximum. imem_rvalid outside WAIT is ignored.
- IF/ID update priority, evaluated each edge:
  1. stallD=1: hold all IF/ID outputs. flushIFID is ignored (hazard unit never asserts both).
  2. flushIFID=1: instr_D=NOP_INSTR, valid_D=0, pc_plus4_D unchanged.
  3. Delivery, as defined in WAIT/HELD above.
  4. Otherwise bubble: instr_D=NOP_INSTR, valid_D=0, pc_plus4_D unchanged.
- Redirect (redirect_valid=1 and stallD=0):
  - pc_F <= redirect_pc, overriding any +4 update in the same cycle.
  - In REQ without gnt: the new address is presented next cycle.
  - In REQ with gnt, or in WAIT without rvalid: set kill=1, go to / stay in WAIT. The stale response is dropped.
  - In WAIT with rvalid: the data is stale; drop it, go to REQ, no delivery.
  - In HELD: drop the buffer, go to REQ.
  - redirect_valid with stallD=1 is ignored; ID re-presents it after the stall.
- pc_F+4 wraps modulo 2^32 with no flag. The low two bits of redirect_pc are forced to 0.
- Reset mid-operation aborts any outstanding request. The imem interface shares rst_n, so no response arrives after reset.

Test Plan:
- Reset + streaming:
  - Stimulus: release rst_n; memory gnt same cycle, rvalid 1 cycle later, data = address.
  - Response: first imem_req the cycle after reset release at 0x0; instr_D 0x0,0x4,0x8 with valid_D=1 and pc_plus4_D 0x4,0x8,0xC; a bubble between each due to 1-outstanding.
- stallF:
  - Stimulus: hold stallF=1 for 3 cycles while in REQ.
  - Response: imem_req=0 throughout; pc_F unchanged; request for the same address on release.
- stallD during return:
  - Stimulus: rvalid arrives with stallD=1 for 2 cycles.
  - Response: IF/ID unchanged during the stall; buffered instruction appears the cycle after stallD falls; pc_F advances exactly once.
- Redirect with outstanding fetch:
  - Stimulus: request 0x10 granted; redirect_valid=1, redirect_pc=0x200 before rvalid.
  - Response: returning 0x10 data dropped (valid_D=0); next imem_addr=0x200; its data delivered with pc_plus4_D=0x204.
- flushIFID vs stallD:
  - Stimulus: flushIFID=1 with stallD=0.
  - Response: valid_D=0, instr_D=NOP_INSTR.
  - Stimulus: both=1.
  - Response: IF/ID held.
- Wrap + async reset:
  - Stimulus: redirect to 0xFFFFFFFC.
  - Response: pc_plus4_D=0x0.
  - Stimulus: assert rst_n mid-WAIT.
  - Response: all outputs reach reset values immediately without a clock edge.
